// File: rtl/csr_file_rv32.sv
// Machine-mode CSR file for the RV32 core: trap state, interrupt enables and pending, trap vector.
// Define CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters; otherwise they read 0.
module csr_file_rv32 #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [11:0] csr_addr_in,
  input  logic        wr_en_in,
  input  logic [31:0] data_wr_in,
  input  logic        trap_taken_in,
  input  logic        int_trap_in,
  input  logic [3:0]  cause_in,
  input  logic [31:0] pc_in,
  input  logic        mret_in,
  input  logic        instret_inc_in,
  input  logic        meip_in,
  input  logic        mtip_in,
  input  logic        msip_in,
  output logic [31:0] csr_data_out,
  output logic        illegal_csr_out,
  output logic [31:0] mepc_out,
  output logic [31:0] trap_address_out,
  output logic        int_pending_out
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNT_W = 64;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic [2:0]      mie_q;         // {meie, mtie, msie}
  logic [29:0]     mtvec_base;
  logic            mtvec_mode;
  logic [XLEN-1:0] mscratch_q;
  logic [29:0]     mepc_q;
  logic            mcause_int;
  logic [3:0]      mcause_code;
  logic [2:0]      mip_c;
  logic [CNT_W-1:0] mcycle_rd;
  logic [CNT_W-1:0] minstret_rd;
  logic [XLEN-1:0] tvec_base_c;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;

  assign wr_mstatus  = wr_en_in && (csr_addr_in == A_MSTATUS);
  assign wr_mie      = wr_en_in && (csr_addr_in == A_MIE);
  assign wr_mtvec    = wr_en_in && (csr_addr_in == A_MTVEC);
  assign wr_mscratch = wr_en_in && (csr_addr_in == A_MSCRATCH);
  assign wr_mepc     = wr_en_in && (csr_addr_in == A_MEPC);
  assign wr_mcause   = wr_en_in && (csr_addr_in == A_MCAUSE);

  assign mip_c = {meip_in, mtip_in, msip_in};

  // Trap state; per field, trap entry beats mret which beats a CSR write.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_base   <= MTVEC_RESET[31:2];
      mtvec_mode   <= MTVEC_RESET[0];
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_int   <= 1'b0;
      mcause_code  <= '0;
    end else begin
      if (trap_taken_in) begin
        mstatus_mie  <= 1'b0;
        mstatus_mpie <= mstatus_mie;
      end else if (mret_in) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr_mstatus) begin
        mstatus_mie  <= data_wr_in[3];
        mstatus_mpie <= data_wr_in[7];
      end
      if (trap_taken_in) begin
        mepc_q      <= pc_in[31:2];
        mcause_int  <= int_trap_in;
        mcause_code <= cause_in;
      end else begin
        if (wr_mepc) mepc_q <= data_wr_in[31:2];
        if (wr_mcause) begin
          mcause_int  <= data_wr_in[31];
          mcause_code <= data_wr_in[3:0];
        end
      end
      if (wr_mie) mie_q <= {data_wr_in[11], data_wr_in[7], data_wr_in[3]};
      if (wr_mtvec) begin
        mtvec_base <= data_wr_in[31:2];
        mtvec_mode <= data_wr_in[0];
      end
      if (wr_mscratch) mscratch_q <= data_wr_in;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [CNT_W-1:0] mcycle_q;
  logic [CNT_W-1:0] minstret_q;

  // A write to either half replaces that half and suppresses the increment.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (wr_en_in && (csr_addr_in == A_MCYCLE))       mcycle_q[31:0]  <= data_wr_in;
      else if (wr_en_in && (csr_addr_in == A_MCYCLEH)) mcycle_q[63:32] <= data_wr_in;
      else                                             mcycle_q <= mcycle_q + CNT_W'(1);
      if (wr_en_in && (csr_addr_in == A_MINSTRET))       minstret_q[31:0]  <= data_wr_in;
      else if (wr_en_in && (csr_addr_in == A_MINSTRETH)) minstret_q[63:32] <= data_wr_in;
      else if (instret_inc_in)                           minstret_q <= minstret_q + CNT_W'(1);
    end
  end

  assign mcycle_rd   = mcycle_q;
  assign minstret_rd = minstret_q;
`else
  logic unused_instret_inc;
  assign unused_instret_inc = instret_inc_in;
  assign mcycle_rd   = '0;
  assign minstret_rd = '0;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_in[1:0];

  // Combinational read decode.
  always_comb begin
    csr_data_out    = '0;
    illegal_csr_out = 1'b0;
    case (csr_addr_in)
      A_MSTATUS:   csr_data_out = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      A_MISA:      csr_data_out = MISA_VALUE;
      A_MIE:       csr_data_out = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
      A_MTVEC:     csr_data_out = {mtvec_base, 1'b0, mtvec_mode};
      A_MSCRATCH:  csr_data_out = mscratch_q;
      A_MEPC:      csr_data_out = {mepc_q, 2'b00};
      A_MCAUSE:    csr_data_out = {mcause_int, 27'b0, mcause_code};
      A_MIP:       csr_data_out = {20'b0, mip_c[2], 3'b0, mip_c[1], 3'b0, mip_c[0], 3'b0};
      A_MCYCLE:    csr_data_out = mcycle_rd[31:0];
      A_MCYCLEH:   csr_data_out = mcycle_rd[63:32];
      A_MINSTRET:  csr_data_out = minstret_rd[31:0];
      A_MINSTRETH: csr_data_out = minstret_rd[63:32];
      12'hF11, 12'hF12, 12'hF13, 12'hF14: csr_data_out = '0;
      default:     illegal_csr_out = 1'b1;
    endcase
  end

  assign mepc_out        = {mepc_q, 2'b00};
  assign tvec_base_c     = {mtvec_base, 2'b00};
  assign trap_address_out = (mtvec_mode && mcause_int) ?
                            tvec_base_c + XLEN'({mcause_code, 2'b00}) : tvec_base_c;
  assign int_pending_out = mstatus_mie && |(mie_q & mip_c);

endmodule

// File: tb/tb_csr_file_rv32.sv
// Bench for csr_file_rv32: directed scenarios plus randomized traffic against an architectural model.
module tb_csr_file_rv32;

  localparam logic [31:0] TB_MTVEC = 32'h0000_0200;
  localparam logic [31:0] TB_MISA  = 32'h4000_0100;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [11:0] csr_addr_in = 12'h0;
  logic        wr_en_in = 1'b0;
  logic [31:0] data_wr_in = 32'h0;
  logic        trap_taken_in = 1'b0;
  logic        int_trap_in = 1'b0;
  logic [3:0]  cause_in = 4'h0;
  logic [31:0] pc_in = 32'h0;
  logic        mret_in = 1'b0;
  logic        instret_inc_in = 1'b0;
  logic        meip_in = 1'b0;
  logic        mtip_in = 1'b0;
  logic        msip_in = 1'b0;
  logic [31:0] csr_data_out;
  logic        illegal_csr_out;
  logic [31:0] mepc_out;
  logic [31:0] trap_address_out;
  logic        int_pending_out;

  csr_file_rv32 #(.MTVEC_RESET(TB_MTVEC), .MISA_VALUE(TB_MISA)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .csr_addr_in(csr_addr_in), .wr_en_in(wr_en_in),
    .data_wr_in(data_wr_in), .trap_taken_in(trap_taken_in), .int_trap_in(int_trap_in),
    .cause_in(cause_in), .pc_in(pc_in), .mret_in(mret_in), .instret_inc_in(instret_inc_in),
    .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in), .csr_data_out(csr_data_out),
    .illegal_csr_out(illegal_csr_out), .mepc_out(mepc_out), .trap_address_out(trap_address_out),
    .int_pending_out(int_pending_out)
  );

  bit clk_run = 1'b0;
  bit chk_en  = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 if (clk_run) clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: each CSR held as its visible 32-bit word.
  logic [31:0] m_mstatus = 32'h1800, m_mie = 32'h0, m_mtvec = TB_MTVEC;
  logic [31:0] m_mscratch = 32'h0, m_mepc = 32'h0, m_mcause = 32'h0;
  logic [63:0] m_cycle = 64'h0, m_instret = 64'h0;

  function automatic bit wr_at(input logic [11:0] a);
    return wr_en_in && (csr_addr_in == a);
  endfunction

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      m_mstatus <= 32'h1800; m_mie <= 32'h0; m_mtvec <= TB_MTVEC;
      m_mscratch <= 32'h0; m_mepc <= 32'h0; m_mcause <= 32'h0;
      m_cycle <= 64'h0; m_instret <= 64'h0;
    end else begin
      if (trap_taken_in)        m_mstatus <= 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      else if (mret_in)         m_mstatus <= 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      else if (wr_at(12'h300))  m_mstatus <= 32'h1800 | (data_wr_in & 32'h88);
      if (trap_taken_in) begin
        m_mepc   <= pc_in & 32'hFFFF_FFFC;
        m_mcause <= (int_trap_in ? 32'h8000_0000 : 32'h0) | 32'(cause_in);
      end else begin
        if (wr_at(12'h341)) m_mepc   <= data_wr_in & 32'hFFFF_FFFC;
        if (wr_at(12'h342)) m_mcause <= data_wr_in & 32'h8000_000F;
      end
      if (wr_at(12'h304)) m_mie      <= data_wr_in & 32'h888;
      if (wr_at(12'h305)) m_mtvec    <= data_wr_in & 32'hFFFF_FFFD;
      if (wr_at(12'h340)) m_mscratch <= data_wr_in;
      if (wr_at(12'hB00))      m_cycle <= {m_cycle[63:32], data_wr_in};
      else if (wr_at(12'hB80)) m_cycle <= {data_wr_in, m_cycle[31:0]};
      else                     m_cycle <= m_cycle + 64'd1;
      if (wr_at(12'hB02))      m_instret <= {m_instret[63:32], data_wr_in};
      else if (wr_at(12'hB82)) m_instret <= {data_wr_in, m_instret[31:0]};
      else if (instret_inc_in) m_instret <= m_instret + 64'd1;
    end
  end

  function automatic logic [31:0] m_mip();
    return (meip_in ? 32'h800 : 32'h0) | (mtip_in ? 32'h80 : 32'h0) | (msip_in ? 32'h8 : 32'h0);
  endfunction

  function automatic logic [63:0] m_cnt(input logic [63:0] v);
`ifdef CSR_COUNTERS_EN
    return v;
`else
    return (v & 64'h0);
`endif
  endfunction

  // Returns {illegal, data}.
  function automatic logic [32:0] m_read(input logic [11:0] a);
    logic [63:0] cyc = m_cnt(m_cycle);
    logic [63:0] ins = m_cnt(m_instret);
    case (a)
      12'h300: return {1'b0, m_mstatus};
      12'h301: return {1'b0, TB_MISA};
      12'h304: return {1'b0, m_mie};
      12'h305: return {1'b0, m_mtvec};
      12'h340: return {1'b0, m_mscratch};
      12'h341: return {1'b0, m_mepc};
      12'h342: return {1'b0, m_mcause};
      12'h344: return {1'b0, m_mip()};
      12'hB00: return {1'b0, cyc[31:0]};
      12'hB80: return {1'b0, cyc[63:32]};
      12'hB02: return {1'b0, ins[31:0]};
      12'hB82: return {1'b0, ins[63:32]};
      12'hF11, 12'hF12, 12'hF13, 12'hF14: return 33'h0;
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic logic [31:0] m_tvec();
    logic [31:0] b = m_mtvec & 32'hFFFF_FFFC;
    if (m_mtvec[0] && m_mcause[31]) return b + 32'd4 * 32'(m_mcause[3:0]);
    return b;
  endfunction

  function automatic logic m_pend();
    return m_mstatus[3] && ((m_mie & m_mip()) != 32'h0);
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    if (chk_en && rst_in) begin
      logic [32:0] r;
      r = m_read(csr_addr_in);
      check("rdata", csr_data_out, r[31:0]);
      check("illegal", 32'(illegal_csr_out), 32'(r[32]));
      check("mepc_out", mepc_out, m_mepc);
      check("trap_addr", trap_address_out, m_tvec());
      check("int_pend", 32'(int_pending_out), 32'(m_pend()));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr_in = a; data_wr_in = d; wr_en_in = 1'b1;
    tick();
    wr_en_in = 1'b0;
  endtask

  task automatic rd(input string n, input logic [11:0] a, input logic [31:0] exp);
    csr_addr_in = a;
    #1;
    check(n, csr_data_out, exp);
  endtask

  logic [11:0] rst_addr [12] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h344, 12'hB00, 12'hB82, 12'hF11, 12'h7C0};
  logic [31:0] rst_exp  [12] = '{32'h1800, 32'h4000_0100, 32'h0, 32'h200, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [11:0] legal [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12,
                              12'hF13, 12'hF14};

  initial begin
    // Reset with the clock idle.
    #2 rst_in = 1'b0;
    #2;
    for (int i = 0; i < 12; i++) begin
      csr_addr_in = rst_addr[i];
      #1;
      check("rst_read", csr_data_out, rst_exp[i]);
    end
    check("rst_illegal_7c0", 32'(illegal_csr_out), 32'h1);
    check("rst_mepc", mepc_out, 32'h0);
    check("rst_tvec", trap_address_out, TB_MTVEC);
    check("rst_intp", 32'(int_pending_out), 32'h0);
    #1 rst_in = 1'b1;
    #1 clk_run = 1'b1;
    tick();
    chk_en = 1'b1;

    // Interrupt pending gating.
    wr(12'h300, 32'h8);
    wr(12'h304, 32'h800);
    meip_in = 1'b1;
    #1 check("intp_on", 32'(int_pending_out), 32'h1);
    wr(12'h304, 32'h0);
    #1 check("intp_off", 32'(int_pending_out), 32'h0);
    meip_in = 1'b0;

    // Interrupt trap entry with vectored mtvec.
    wr(12'h305, 32'h1001);
    trap_taken_in = 1'b1; int_trap_in = 1'b1; cause_in = 4'd11; pc_in = 32'h104;
    tick();
    trap_taken_in = 1'b0; int_trap_in = 1'b0;
    check("trap_mepc", mepc_out, 32'h104);
    rd("trap_mcause", 12'h342, 32'h8000_000B);
    rd("trap_mstatus", 12'h300, 32'h1880);
    check("trap_vec", trap_address_out, 32'h102C);

    // Trap beats a same-cycle mstatus write; mret restores MIE.
    wr(12'h300, 32'h8);
    csr_addr_in = 12'h300; data_wr_in = 32'h8; wr_en_in = 1'b1;
    trap_taken_in = 1'b1; cause_in = 4'd2; pc_in = 32'h207;
    tick();
    wr_en_in = 1'b0; trap_taken_in = 1'b0;
    rd("trapwr_mstatus", 12'h300, 32'h1880);
    check("trapwr_mepc_mask", mepc_out, 32'h204);
    check("exc_vec_base", trap_address_out, 32'h1000);
    mret_in = 1'b1;
    tick();
    mret_in = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h1888);

    // Counter carry, wrap and instret.
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    tick();
`ifdef CSR_COUNTERS_EN
    rd("mcycleh_carry", 12'hB80, 32'h1);
    rd("mcycle_carry", 12'hB00, 32'h0);
`else
    rd("mcycleh_off", 12'hB80, 32'h0);
    rd("mcycle_off", 12'hB00, 32'h0);
`endif
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFF);
    tick();
    rd("mcycle_wrap", 12'hB00, 32'h0);
    rd("mcycleh_wrap", 12'hB80, 32'h0);
    wr(12'hB02, 32'h5);
    instret_inc_in = 1'b1;
    repeat (3) tick();
    instret_inc_in = 1'b0;
`ifdef CSR_COUNTERS_EN
    rd("minstret_inc", 12'hB02, 32'h8);
`else
    rd("minstret_off", 12'hB02, 32'h0);
`endif

    // Unimplemented address.
    csr_addr_in = 12'h7C0;
    #1;
    check("illegal_data", csr_data_out, 32'h0);
    check("illegal_flag", 32'(illegal_csr_out), 32'h1);
    wr(12'h7C0, 32'hFFFF_FFFF);
    rd("illegal_wr_mscratch", 12'h340, 32'h0);
    rd("illegal_wr_mstatus", 12'h300, 32'h1888);

    // Randomized traffic, with one asynchronous reset landing on a trap.
    for (int i = 0; i < 3000; i++) begin
      csr_addr_in    = ($urandom_range(0, 7) == 0) ? 12'($urandom) : legal[$urandom_range(0, 15)];
      wr_en_in       = ($urandom_range(0, 2) == 0);
      data_wr_in     = $urandom;
      trap_taken_in  = ($urandom_range(0, 15) == 0);
      int_trap_in    = 1'($urandom);
      cause_in       = 4'($urandom);
      pc_in          = $urandom;
      mret_in        = ($urandom_range(0, 15) == 0);
      instret_inc_in = 1'($urandom);
      meip_in        = 1'($urandom);
      mtip_in        = 1'($urandom);
      msip_in        = 1'($urandom);
      if (i == 1500) begin
        trap_taken_in = 1'b1;
        #2 rst_in = 1'b0;
        #1;
        check("midrst_mepc", mepc_out, 32'h0);
        check("midrst_tvec", trap_address_out, TB_MTVEC);
        check("midrst_intp", 32'(int_pending_out), 32'h0);
        #2 rst_in = 1'b1;
      end
      tick();
    end
    wr_en_in = 1'b0; trap_taken_in = 1'b0; mret_in = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_file_rv32.md
# csr_file_rv32

Machine-mode CSR register file for the RV32 core. It consumes the merged write word produced by the CSR write-data mux and returns the current CSR value that feeds back into that mux as the read operand. It holds trap state (mstatus, mie, mtvec, mscratch, mepc, mcause) and the cycle/instret counters. It also produces the trap vector, the saved mepc and the interrupt-pending request for the pipeline control.

## Interface
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- MISA_VALUE, 32'h4000_0100, read-only value of misa (RV32I).
- clk_in  input  1  core clock; all state updates on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- csr_addr_in  input  12  CSR address for read and write.
- wr_en_in  input  1  commit data_wr_in to csr_addr_in this cycle.
- data_wr_in  input  32  merged write word (RW/RS/RC already applied).
- trap_taken_in  input  1  single-cycle pulse: enter trap this cycle.
- int_trap_in  input  1  qualifies trap_taken_in: 1 = interrupt, 0 = exception.
- cause_in  input  4  exception/interrupt code.
- pc_in  input  32  PC to save into mepc on trap.
- mret_in  input  1  single-cycle pulse: return from trap.
- instret_inc_in  input  1  one instruction retired this cycle.
- meip_in, mtip_in, msip_in  input  1 each  external/timer/software interrupt lines (level).
- csr_data_out  output  32  current value at csr_addr_in (combinational).
- illegal_csr_out  output  1  csr_addr_in not implemented.
- mepc_out  output  32  current mepc.
- trap_address_out  output  32  trap target PC.
- int_pending_out  output  1  enabled interrupt pending and globally enabled.

## Operation
- Address map: mstatus 0x300 (MIE bit3, MPIE bit7, MPP bits12:11 read 2'b11, other bits 0); misa 0x301 (MISA_VALUE, writes ignored); mie 0x304 (bits 11/7/3 writable, others 0); mtvec 0x305 (bits31:2 base, bit0 mode, bit1 reads 0); mscratch 0x340 (full 32b); mepc 0x341 (bits1:0 forced 0); mcause 0x342 (bit31 interrupt flag, bits3:0 code); mip 0x344 (bit11 meip_in, bit7 mtip_in, bit3 msip_in, read-only); mcycle/mcycleh 0xB00/0xB80; minstret/minstreth 0xB02/0xB82; 0xF11–0xF14 read 0.
- Any other address: csr_data_out = 0, illegal_csr_out = 1, write ignored.
- Trap entry on trap_taken_in:
  - mepc <= {pc_in[31:2],2'b00}
  - mcause <= {int_trap_in, 27'b0, cause_in}
  - MPIE <= MIE, MIE <= 0
- mret_in: MIE <= MPIE, MPIE <= 1.
- Priority per field:
  - trap_taken_in over mret_in over wr_en_in.
  - Non-conflicting fields all update in the same cycle.
- trap_address_out: when mtvec mode = 1 and mcause[31] = 1, {base,2'b00} + 4*mcause[3:0]; otherwise {base,2'b00}. Uses the registered mcause.
- int_pending_out = MIE & |(mie & mip) over bits 11/7/3.

## Timing
- Reads are combinational from csr_addr_in and current state, with zero latency.
- Writes, trap entry and mret take effect at the rising edge. The new value is visible the following cycle.
- Reset (rst_in low, asynchronous, including mid-trap):
  - mtvec = MTVEC_RESET; all other state = 0, except MPIE = 0 and MIE = 0.
  - Outputs at reset: csr_data_out per address decode of the reset state, int_pending_out = 0, mepc_out = 0, trap_address_out = MTVEC_RESET.
- Counters: mcycle (64b) increments every cycle, with carry from the low to the high word.
  - A write to either half takes the written value that cycle, with no increment.
  - Wrap from all-ones to 0 without a flag.
  - minstret behaves identically, gated by instret_inc_in.

## Configuration
- CSR_COUNTERS_EN defined: mcycle/minstret 64-bit counters implemented as above.
- Not defined:
  - 0xB00/0xB80/0xB02/0xB82 still decode as legal (illegal_csr_out = 0).
  - They read 0 and writes are ignored.
  - No counter flops are synthesized.

## Test plan
- Reset with clk idle -> all reads 0 except mstatus = 0x0000_1800, misa = 0x4000_0100, mtvec = MTVEC_RESET; int_pending_out = 0.
- Write mstatus 0x8, mie 0x800, then assert meip_in -> int_pending_out = 1 next cycle; clear mie -> 0.
- Set MIE = 1, pulse trap_taken_in with int_trap_in = 1, cause 11, pc 0x104 -> mepc = 0x104, mcause = 0x8000_000B, MIE = 0, MPIE = 1. With mtvec = 0x1001, trap_address_out = 0x102C.
- trap_taken_in and wr_en_in to mstatus with 0x8 in the same cycle -> MIE = 0 (trap wins). A following mret_in -> MIE = 1.
- Write mcycle 0xFFFF_FFFF, mcycleh 0 -> two cycles later mcycleh = 1, mcycle = 0 (with CSR_COUNTERS_EN); without the macro both read 0.
- Read 0x7C0 -> csr_data_out = 0, illegal_csr_out = 1; a write to 0x7C0 changes no state.
